sprite_line_scheduler: RTL and testbench

// Per-scanline sprite sequencer for the 40 per-sprite units. During OAM

---
 rtl/sprite_line_scheduler.sv | 171 +++++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite sequencer: scans OAM Y bytes for up to MAX_SPR sprites
// visible on v_cnt, then fetches both tile bitplanes for each selected sprite.
module sprite_line_scheduler #(
    parameter int MAX_SPR = 10,
    parameter int NUM_SPR = 40
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       size16,
    input  logic [7:0] v_cnt,
    input  logic       line_start,
    input  logic       fetch_go,
    output logic [7:0] oam_addr,
    input  logic [7:0] oam_data,
    output logic       vram_req,
    output logic       vram_plane,
    input  logic       vram_ack,
    output logic [5:0] spr_sel,
    output logic [1:0] spr_ds,
    output logic [3:0] sprite_count,
    output logic       scan_busy,
    output logic       fetch_busy,
    output logic       done
);

    localparam logic [3:0] MAX_CNT  = 4'(MAX_SPR);
    localparam logic [5:0] LAST_IDX = 6'(NUM_SPR - 1);
    localparam logic [5:0] NO_SPR   = 6'd63;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        READY,
        FETCH_LO,
        FETCH_HI,
        DONE
    } state_t;

    state_t     state;
    logic [5:0] idx;
    logic       phase_b;
    logic [3:0] count;
    logic [3:0] k;
    logic       req_r;
    logic [5:0] list [MAX_SPR];

    logic [7:0] height;
    logic [7:0] line_pos;
    logic [7:0] y_end;
    logic       visible;

    // 8-bit wrapping arithmetic, identical to the per-sprite unit's v_visible
    assign height   = size16 ? 8'd16 : 8'd8;
    assign line_pos = v_cnt + 8'd16;
    assign y_end    = oam_data + height;
    assign visible  = (line_pos >= oam_data) && (line_pos < y_end);

    assign vram_req     = req_r & ~line_start & enable;
    assign sprite_count = count;

    always_comb begin
        spr_ds = 2'b00;
        if (enable && !line_start && req_r && vram_ack) begin
            if (state == FETCH_LO)
                spr_ds = 2'b01;
            else if (state == FETCH_HI)
                spr_ds = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            phase_b    <= 1'b0;
            count      <= '0;
            k          <= '0;
            req_r      <= 1'b0;
            vram_plane <= 1'b0;
            spr_sel    <= NO_SPR;
            oam_addr   <= '0;
            scan_busy  <= 1'b0;
            fetch_busy <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < MAX_SPR; i++)
                list[i] <= '0;
        end else if (!enable || line_start) begin
            // line_start abandons any work in progress and rescans from sprite 0
            state      <= enable ? SCAN : IDLE;
            idx        <= '0;
            phase_b    <= 1'b0;
            count      <= '0;
            k          <= '0;
            req_r      <= 1'b0;
            vram_plane <= 1'b0;
            spr_sel    <= NO_SPR;
            oam_addr   <= '0;
            scan_busy  <= enable;
            fetch_busy <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: done <= 1'b0;
                SCAN: begin
                    if (!phase_b) begin
                        phase_b <= 1'b1;
                    end else begin
                        phase_b <= 1'b0;
                        if (visible && (count < MAX_CNT)) begin
                            list[count] <= idx;
                            count       <= count + 4'd1;
                        end
                        if (idx == LAST_IDX) begin
                            state     <= READY;
                            scan_busy <= 1'b0;
                            oam_addr  <= '0;
                        end else begin
                            idx      <= idx + 6'd1;
                            oam_addr <= {idx + 6'd1, 2'b00};
                        end
                    end
                end
                READY: begin
                    if (fetch_go) begin
                        if (count == 4'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= FETCH_LO;
                            k          <= '0;
                            spr_sel    <= list[0];
                            req_r      <= 1'b1;
                            vram_plane <= 1'b0;
                            fetch_busy <= 1'b1;
                        end
                    end
                end
                FETCH_LO: begin
                    if (vram_ack) begin
                        state      <= FETCH_HI;
                        vram_plane <= 1'b1;
                    end
                end
                FETCH_HI: begin
                    if (vram_ack) begin
                        if ((k + 4'd1) == count) begin
                            state      <= DONE;
                            req_r      <= 1'b0;
                            vram_plane <= 1'b0;
                            spr_sel    <= NO_SPR;
                            fetch_busy <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            state      <= FETCH_LO;
                            k          <= k + 4'd1;
                            spr_sel    <= list[k + 4'd1];
                            vram_plane <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench for sprite_line_scheduler: directed scenarios push expected
// scan/strobe/done events; a negedge monitor pops and compares them.
module tb_sprite_line_scheduler;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       size16;
    logic [7:0] v_cnt;
    logic       line_start;
    logic       fetch_go;
    logic [7:0] oam_addr;
    logic [7:0] oam_data;
    logic       vram_req;
    logic       vram_plane;
    logic       vram_ack;
    logic [5:0] spr_sel;
    logic [1:0] spr_ds;
    logic [3:0] sprite_count;
    logic       scan_busy;
    logic       fetch_busy;
    logic       done;

    logic       resp_ack;
    logic       stray_ack;
    int         ack_delay;
    logic [7:0] oam [0:255];

    typedef struct {
        int kind;
        int a;
        int b;
        int c;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;

    sprite_line_scheduler dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .size16(size16),
        .v_cnt(v_cnt), .line_start(line_start), .fetch_go(fetch_go),
        .oam_addr(oam_addr), .oam_data(oam_data), .vram_req(vram_req),
        .vram_plane(vram_plane), .vram_ack(vram_ack), .spr_sel(spr_sel),
        .spr_ds(spr_ds), .sprite_count(sprite_count), .scan_busy(scan_busy),
        .fetch_busy(fetch_busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // OAM answers one cycle after the address
    always @(posedge clk) oam_data <= oam[oam_addr];

    assign vram_ack = resp_ack | stray_ack;

    // VRAM model: grants each request after ack_delay waiting cycles
    initial begin
        int rcnt;
        resp_ack = 1'b0;
        rcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_ack) begin
                resp_ack = 1'b0;
                rcnt = 0;
            end
            if (vram_req) begin
                if (rcnt == ack_delay) resp_ack = 1'b1;
                else rcnt++;
            end else begin
                rcnt = 0;
            end
        end
    end

    task automatic popCompare(input int kind, input int a, input int b, input int c, input string name);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: unexpected event got (%0d,%0d,%0d) required none", name, a, b, c);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.a != a || e.b != b || e.c != c) begin
                errors++;
                $display("[TB] FAIL %s: got kind%0d (%0d,%0d,%0d) required kind%0d (%0d,%0d,%0d)",
                         name, kind, a, b, c, e.kind, e.a, e.b, e.c);
            end
        end
    endtask

    // Monitor: scan length/count at scan end, every strobe, every done pulse
    initial begin
        int  scan_cnt;
        int  mon_wait;
        bit  scan_prev;
        scan_cnt = 0;
        mon_wait = 0;
        scan_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                scan_cnt = 0;
                scan_prev = 1'b0;
                mon_wait = 0;
            end else begin
                if (scan_busy) begin
                    scan_cnt++;
                    scan_prev = 1'b1;
                end else if (scan_prev) begin
                    popCompare(2, int'(sprite_count), scan_cnt, 0, "scan_end");
                    scan_prev = 1'b0;
                    scan_cnt = 0;
                end
                if (spr_ds != 2'b00 || (vram_ack && vram_req)) begin
                    popCompare(0, int'(spr_sel), int'({vram_plane, spr_ds}), mon_wait, "strobe");
                    mon_wait = 0;
                end else if (vram_req) begin
                    mon_wait++;
                end else begin
                    mon_wait = 0;
                end
                if (done) popCompare(1, int'(sprite_count), 0, 0, "done");
            end
        end
    end

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic pushEv(input int kind, input int a, input int b, input int c);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c;
        sb.push_back(e);
    endtask

    task automatic pushFetch(input int sel, input int waitc);
        pushEv(0, sel, 1, waitc);
        pushEv(0, sel, 6, waitc);
    endtask

    task automatic fillOam(input logic [7:0] y);
        for (int i = 0; i < 256; i++) oam[i] = y;
    endtask

    task automatic applyStimulus(input logic [7:0] v, input logic s16);
        v_cnt = v;
        size16 = s16;
        line_start = 1'b1;
        @(posedge clk); #2;
        line_start = 1'b0;
    endtask

    task automatic pulseGo();
        fetch_go = 1'b1;
        @(posedge clk); #2;
        fetch_go = 1'b0;
    endtask

    // 0: scan finished, 1: done pulse, 2: high-plane fetch in progress
    task automatic waitFor(input int which, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ((which == 0 && !scan_busy) || (which == 1 && done) ||
                (which == 2 && vram_plane && fetch_busy)) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: timed out got no event required event", name);
        end
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #2;
        checkOutput("sb_empty", sb.size(), 0);
        checkOutput("idle_sel", int'(spr_sel), 63);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b1; size16 = 1'b0; v_cnt = 8'd0;
        line_start = 1'b0; fetch_go = 1'b0; stray_ack = 1'b0; ack_delay = 0;
        fillOam(8'd0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_state", int'({oam_addr, vram_req, vram_plane, spr_sel, spr_ds}),
                    int'({8'd0, 1'b0, 1'b0, 6'd63, 2'b00}));
        checkOutput("rst_flags", int'({sprite_count, scan_busy, fetch_busy, done}), 0);
        reset_n = 1'b1;
        @(posedge clk); #2;

        // Sprites 3 and 7 on line 50 (y = 66); stray acks and early fetch_go ignored
        $display("[TB] two visible sprites");
        oam[12] = 8'd66;
        oam[28] = 8'd66;
        pushEv(2, 2, 80, 0);
        pushFetch(3, 0);
        pushFetch(7, 0);
        pushEv(1, 2, 0, 0);
        applyStimulus(8'd50, 1'b0);
        pulseGo();
        waitFor(0, "ready_two");
        stray_ack = 1'b1;
        #1;
        checkOutput("stray_ds", int'(spr_ds), 0);
        @(posedge clk); #2;
        stray_ack = 1'b0;
        pulseGo();
        waitFor(1, "done_two");
        settle();

        // Every sprite visible: list saturates at the first ten
        $display("[TB] all sprites visible");
        fillOam(8'd66);
        pushEv(2, 10, 80, 0);
        for (int i = 0; i < 10; i++) pushFetch(i, 0);
        pushEv(1, 10, 0, 0);
        applyStimulus(8'd50, 1'b0);
        waitFor(0, "ready_all");
        pulseGo();
        waitFor(1, "done_all");
        settle();

        // y = v+4 is row 12: visible only in 8x16 mode
        $display("[TB] tall sprite row 12");
        fillOam(8'd0);
        oam[20] = 8'd54;
        pushEv(2, 1, 80, 0);
        pushFetch(5, 0);
        pushEv(1, 1, 0, 0);
        applyStimulus(8'd50, 1'b1);
        waitFor(0, "ready_tall");
        pulseGo();
        waitFor(1, "done_tall");
        settle();
        pushEv(2, 0, 80, 0);
        pushEv(1, 0, 0, 0);
        applyStimulus(8'd50, 1'b0);
        waitFor(0, "ready_short");
        pulseGo();
        waitFor(1, "done_none");
        settle();

        // Line 250 wraps to 10; slow VRAM holds each request for 5 cycles
        $display("[TB] wrap and slow ack");
        fillOam(8'd200);
        oam[48] = 8'd10;
        ack_delay = 5;
        pushEv(2, 1, 80, 0);
        pushFetch(12, 5);
        pushEv(1, 1, 0, 0);
        applyStimulus(8'd250, 1'b0);
        waitFor(0, "ready_wrap");
        pulseGo();
        waitFor(1, "done_wrap");
        settle();

        // line_start during the high-plane fetch aborts without a done pulse
        $display("[TB] abort mid fetch");
        fillOam(8'd0);
        oam[12] = 8'd66;
        oam[28] = 8'd66;
        ack_delay = 20;
        pushEv(2, 2, 80, 0);
        pushEv(0, 3, 1, 20);
        applyStimulus(8'd50, 1'b0);
        waitFor(0, "ready_abort");
        pulseGo();
        waitFor(2, "fetch_hi");
        line_start = 1'b1;
        #1;
        checkOutput("abort_req", int'(vram_req), 0);
        @(posedge clk); #2;
        line_start = 1'b0;
        checkOutput("abort_scan", int'({scan_busy, fetch_busy, sprite_count}), int'({1'b1, 1'b0, 4'd0}));
        pushEv(2, 2, 80, 0);
        waitFor(0, "ready_rescan");
        settle();
        ack_delay = 0;
        pushFetch(3, 0);
        pushFetch(7, 0);
        pushEv(1, 2, 0, 0);
        pulseGo();
        waitFor(1, "done_rescan");
        settle();

        // Asynchronous reset in the middle of a scan
        $display("[TB] reset mid scan");
        applyStimulus(8'd50, 1'b0);
        repeat (20) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst", int'({oam_addr, spr_sel, scan_busy, sprite_count, vram_req}),
                    int'({8'd0, 6'd63, 1'b0, 4'd0, 1'b0}));
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
